// File: rtl/ifid_latch.sv
// ifid_latch -- IF/ID pipeline register for the 16-bit RISC core.
//
// Captures the fetched instruction and its PC+2. Flush and stall are applied
// here. HALT is detected on capture and blocks further issue until a flush or
// reset. The latched opcode is pre-decoded into imm_out and ext_mode so the
// decode-stage sign extender can use them in the same cycle.
//
// Optional feature: define IFID_BUBBLE_CNT_EN to add the bubble_cnt output.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   instr_in        instruction from fetch (16)
//   pc_plus2_in     PC+2 from fetch (16)
//   valid_in        fetch output is a real instruction
//   stall           hold current contents
//   flush           squash current contents (overrides stall)
//   instr_out       latched instruction (16)
//   pc_plus2_out    latched PC+2 (16)
//   valid_out       instr_out is a real instruction
//   imm_out         instr_out[10:0]
//   ext_mode        sign-extension mode from the latched opcode
//                   (00 5b zero, 01 5b sign, 10 8b sign, 11 11b sign)
//   halted          HALT captured; issue suppressed
//   bubble_cnt      (IFID_BUBBLE_CNT_EN only) count of edges that load valid_out=0
module ifid_latch #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_plus2_in,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out,
  output logic [10:0] imm_out,
  output logic [1:0]  ext_mode,
`ifdef IFID_BUBBLE_CNT_EN
  output logic [15:0] bubble_cnt,
`endif
  output logic        halted
);

  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  // Set on every non-reset edge that loads valid_out=0 (never on a stall).
  logic        bubble_ld;

  // Priority below reset: flush > stall > halted > capture.
  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    bubble_ld = 1'b0;
    if (flush) begin
      // PC+2 is intentionally left alone on a flush.
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      halted_d  = 1'b0;
      bubble_ld = 1'b1;
    end else if (stall) begin
      // hold everything, halted included
    end else if (halted_q) begin
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      bubble_ld = 1'b1;
    end else begin
      instr_d   = instr_in;
      pc_d      = pc_plus2_in;
      valid_d   = valid_in;
      // HALT stays visible for this cycle; issue is suppressed from the next edge.
      halted_d  = valid_in && (instr_in[15:11] == HALT_OPC);
      bubble_ld = !valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= NOP_INSTR;
      pc_q     <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_q, bubble_d;

  // Wraps naturally at 16'hFFFF -> 0.
  assign bubble_d = bubble_ld ? bubble_q + 16'd1 : bubble_q;

  always_ff @(posedge clk) begin
    if (rst) bubble_q <= 16'h0000;
    else     bubble_q <= bubble_d;
  end

  assign bubble_cnt = bubble_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_ld;
`endif

  // Decode from the latched word only; valid_out plays no part.
  always_comb begin
    unique case (instr_q[15:11])
      5'b01000, 5'b01001,
      5'b10000, 5'b10001, 5'b10011:            ext_mode = 2'b01;
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b11000, 5'b10010,
      5'b00101, 5'b00111:                      ext_mode = 2'b10;
      5'b00100, 5'b00110:                      ext_mode = 2'b11;
      // XORI, ANDNI, shift/rotate immediates and everything else
      default:                                 ext_mode = 2'b00;
    endcase
  end

  assign instr_out    = instr_q;
  assign pc_plus2_out = pc_q;
  assign valid_out    = valid_q;
  assign halted       = halted_q;
  assign imm_out      = instr_q[10:0];

endmodule

// File: tb/tb_ifid_latch.sv
// Directed testbench for ifid_latch. Inputs change 1 time unit after a rising
// edge; outputs are checked 1 time unit after the following rising edge.
module tb_ifid_latch;

  logic        clk = 1'b0;
  logic        rst, valid_in, stall, flush;
  logic [15:0] instr_in, pc_plus2_in;
  logic [15:0] instr_out, pc_plus2_out;
  logic        valid_out, halted;
  logic [10:0] imm_out;
  logic [1:0]  ext_mode;
`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-derived ext_mode for each opcode 0..31.
  logic [1:0] exp_tbl [32];

  ifid_latch dut (
    .clk(clk), .rst(rst),
    .instr_in(instr_in), .pc_plus2_in(pc_plus2_in), .valid_in(valid_in),
    .stall(stall), .flush(flush),
    .instr_out(instr_out), .pc_plus2_out(pc_plus2_out), .valid_out(valid_out),
    .imm_out(imm_out), .ext_mode(ext_mode),
`ifdef IFID_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [15:0] ins, input logic [15:0] pc);
    rst = r; stall = s; flush = f; valid_in = v; instr_in = ins; pc_plus2_in = pc;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_tbl = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11, 2'b10,
                2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
                2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    instr_in = 16'h0000; pc_plus2_in = 16'h0000;
    #1;

    // Reset for two cycles, with a valid instruction presented.
    step(1, 0, 0, 1, 16'h4123, 16'h0102);
    step(1, 0, 0, 1, 16'h4123, 16'h0102);
    chk("rst_instr",  instr_out,    16'h0800);
    chk("rst_pc",     pc_plus2_out, 16'h0000);
    chk("rst_valid",  valid_out,    0);
    chk("rst_halted", halted,       0);
    chk("rst_ext",    ext_mode,     2'b00);
`ifdef IFID_BUBBLE_CNT_EN
    chk("rst_bub",    bubble_cnt,   0);
`endif

    // Capture ADDI.
    step(0, 0, 0, 1, 16'h4123, 16'h0102);
    chk("cap_instr", instr_out,    16'h4123);
    chk("cap_ext",   ext_mode,     2'b01);
    chk("cap_imm",   imm_out,      11'h123);
    chk("cap_valid", valid_out,    1);
    chk("cap_pc",    pc_plus2_out, 16'h0102);

    // Latch J, then stall for 3 cycles while the input changes.
    step(0, 0, 0, 1, 16'h2405, 16'h0104);
    chk("j_instr", instr_out, 16'h2405);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 1, 16'h6000 + 16'(k), 16'h0300 + 16'(k));
      chk("stl_instr", instr_out,    16'h2405);
      chk("stl_ext",   ext_mode,     2'b11);
      chk("stl_pc",    pc_plus2_out, 16'h0104);
      chk("stl_valid", valid_out,    1);
    end

    // Flush beats stall; PC+2 is kept.
    step(0, 1, 1, 1, 16'h4444, 16'h0500);
    chk("fls_instr", instr_out,    16'h0800);
    chk("fls_valid", valid_out,    0);
    chk("fls_pc",    pc_plus2_out, 16'h0104);
`ifdef IFID_BUBBLE_CNT_EN
    chk("fls_bub",   bubble_cnt,   1);
`endif

    // HALT captured and visible for one cycle.
    step(0, 0, 0, 1, 16'h0000, 16'h0200);
    chk("hlt_instr",  instr_out, 16'h0000);
    chk("hlt_valid",  valid_out, 1);
    chk("hlt_halted", halted,    1);
    // Issue suppressed.
    step(0, 0, 0, 1, 16'h5001, 16'h0202);
    chk("sup_instr",  instr_out,    16'h0800);
    chk("sup_valid",  valid_out,    0);
    chk("sup_halted", halted,       1);
    chk("sup_pc",     pc_plus2_out, 16'h0200);
    // Stall while halted keeps halted.
    step(0, 1, 0, 1, 16'h5001, 16'h0202);
    chk("hstl_halted", halted, 1);
    step(0, 0, 0, 1, 16'h5001, 16'h0202);
    chk("sup2_instr", instr_out, 16'h0800);
`ifdef IFID_BUBBLE_CNT_EN
    chk("sup_bub",    bubble_cnt, 3);
`endif
    // Flush clears halted, then XORI captures.
    step(0, 0, 1, 1, 16'h5001, 16'h0202);
    chk("unh_halted", halted,    0);
    chk("unh_valid",  valid_out, 0);
    step(0, 0, 0, 1, 16'h5001, 16'h0202);
    chk("xor_instr", instr_out, 16'h5001);
    chk("xor_ext",   ext_mode,  2'b00);
    chk("xor_imm",   imm_out,   11'h001);
    chk("xor_valid", valid_out, 1);
    chk("xor_pc",    pc_plus2_out, 16'h0202);

    // Halt again, then reset while halted and stalled.
    step(0, 0, 0, 1, 16'h0000, 16'h0400);
    chk("hlt2_halted", halted, 1);
    step(1, 1, 0, 1, 16'h0000, 16'h0400);
    chk("rsth_halted", halted,       0);
    chk("rsth_instr",  instr_out,    16'h0800);
    chk("rsth_pc",     pc_plus2_out, 16'h0000);
    chk("rsth_valid",  valid_out,    0);

    // Decode sweep; valid_in=0 so opcode 0 does not halt.
    for (int op = 0; op < 32; op++) begin
      step(0, 0, 0, 0, {5'(op), 11'h7FF}, 16'h1000);
      chk($sformatf("swp_ext_%0d", op), ext_mode, exp_tbl[op]);
      chk($sformatf("swp_imm_%0d", op), imm_out,  11'h7FF);
    end
    chk("swp_halted", halted, 0);
`ifdef IFID_BUBBLE_CNT_EN
    chk("swp_bub", bubble_cnt, 32);

    // Counter wrap: from reset, 65535 bubbles then one more.
    step(1, 0, 0, 0, 16'h0800, 16'h0000);
    for (int k = 0; k < 65535; k++) step(0, 0, 0, 0, 16'h0800, 16'h0000);
    chk("wrap_ffff", bubble_cnt, 16'hFFFF);
    step(0, 0, 0, 0, 16'h0800, 16'h0000);
    chk("wrap_zero", bubble_cnt, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_latch.md
# ifid_latch

IF/ID pipeline register for the 16-bit RISC core. It captures the fetched instruction and PC+2 and applies stall and flush control. It pre-decodes the opcode into the 11-bit immediate field and 2-bit extension-mode code that the decode stage's sign extender consumes in the same cycle. It also detects HALT and suppresses further issue until a flush or reset.

## Interface
Parameters:
- NOP_INSTR, 16'h0800, instruction word loaded on reset/flush/bubble (opcode 5'b00001, NOP)
- HALT_OPC, 5'b00000, opcode treated as HALT

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- instr_in  input  16  instruction from fetch
- pc_plus2_in  input  16  PC+2 from fetch
- valid_in  input  1  fetch output is a real instruction
- stall  input  1  hazard unit: hold current contents
- flush  input  1  branch/jump resolved taken: squash current contents
- instr_out  output  16  latched instruction
- pc_plus2_out  output  16  latched PC+2
- valid_out  output  1  instr_out is a real instruction
- imm_out  output  11  instr_out[10:0], combinational from latch
- ext_mode  output  2  extension mode for the sign extender, combinational from latched opcode
- halted  output  1  HALT captured; issue suppressed

## Operation
- Reset: instr_out=NOP_INSTR, pc_plus2_out=0, valid_out=0, halted=0. If the bubble counter is compiled in, bubble_cnt=0.
- Priority each edge: rst > flush > stall > halted > capture.
- flush: load NOP_INSTR, valid_out=0, halted=0. pc_plus2_out is unchanged. Flush overrides a simultaneous stall.
- stall (no flush): all registers hold, including halted.
- halted=1 (no stall/flush): load NOP_INSTR, valid_out=0. instr_in is ignored.
- capture: instr_out=instr_in, pc_plus2_out=pc_plus2_in, valid_out=valid_in. If valid_in=1 and instr_in[15:11]=HALT_OPC, set halted=1 in the same edge.
- ext_mode decode, from instr_out[15:11] (00 = 5-bit zero, 01 = 5-bit sign, 10 = 8-bit sign, 11 = 11-bit sign):
  - 00: 01010 XORI, 01011 ANDNI, 10100–10111 rotate/shift immediates
  - 01: 01000 ADDI, 01001 SUBI, 10000 ST, 10001 LD, 10011 STU
  - 10: 01100–01111 branches, 11000 LBI, 10010 SLBI (consumer uses low 8 bits only), 00101 JR, 00111 JALR
  - 11: 00100 J, 00110 JAL
  - 00: all other opcodes
- ext_mode and imm_out depend only on the latched instr_out. They do not depend on valid_out.

## Timing
- Latency: 1 cycle. Input present at edge N appears on outputs after edge N.
- ext_mode and imm_out are combinational from registers. There is no input-to-output combinational path.
- Stall held for K cycles: outputs are stable for K cycles. Capture resumes on the first edge with stall=0.
- HALT at edge N: halted=1 after edge N. The HALT instruction itself remains in instr_out with valid_out=1 for one cycle, or longer while stalled. From edge N+1 onward, NOP with valid_out=0.
- Reset asserted mid-stall or while halted: reset values after the next edge, regardless of other inputs.

## Configuration
- IFID_BUBBLE_CNT_EN defined:
  - Adds output bubble_cnt (16 bits), reset 0.
  - Increments by 1, wrapping at 16'hFFFF→0, on every non-reset edge where the value loaded into valid_out is 0. This covers flush, halted, and capture with valid_in=0. Stall edges do not count.
- IFID_BUBBLE_CNT_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then capture: rst=1 for 2 cycles, then instr_in=16'h4123 (ADDI), valid_in=1 -> after the reset edge instr_out=16'h0800, valid_out=0; after the capture edge instr_out=16'h4123, ext_mode=01, imm_out=11'h123, valid_out=1.
- Stall hold: latch 16'h2405 (J), then stall=1 for 3 cycles with instr_in changing each cycle -> instr_out stays 16'h2405 and ext_mode stays 11 for all 3 cycles.
- Flush beats stall: stall=1, flush=1 together -> instr_out=16'h0800, valid_out=0, pc_plus2_out unchanged. With the counter compiled in, bubble_cnt +1.
- HALT suppression: capture 16'h0000 with valid_in=1, then feed 16'h5001 (XORI) -> HALT visible for 1 cycle, then halted=1, instr_out=16'h0800, valid_out=0. A later flush clears halted, and 16'h5001 captures with ext_mode=00.
- Decode sweep: all 32 opcodes with instr[10:0]=11'h7FF -> ext_mode matches the table for each opcode, imm_out=11'h7FF.
- Counter wrap (IFID_BUBBLE_CNT_EN): 65536 edges with valid_in=0 -> bubble_cnt returns to 0.
